// File: rtl/counter_pkg.sv
// Shared types and helpers for the parametrised counter: direction encoding,
// default range helper and binary-to-Gray conversion.
package counter_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_t;

  // Widest counter the Gray helper handles; callers cast down to their width.
  localparam int GRAY_MAX_W = 32;

  function automatic int default_max_val(input int width);
    return (1 << width) - 1;
  endfunction

  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/counter_core.sv
// Next-state and limit logic for the counter: computes next_bin and the
// terminal/overflow/underflow event bits for the coming edge.
module counter_core
  import counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MAX_VAL  = default_max_val(WIDTH),
  parameter bit SATURATE = 1'b0
) (
  input  logic [WIDTH-1:0] count_bin,
  input  logic             enable,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] next_bin,
  output logic             tc_event,
  output logic             ovf_event,
  output logic             unf_event
);

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] cur_bin;
  logic [WIDTH:0]   inc_sum;
  logic [WIDTH:0]   dec_diff;
  logic             at_max;
  logic             at_zero;
  dir_t             dir;

  // Out-of-range register contents behave as MAX_VAL when counting.
  assign cur_bin  = (count_bin > MAX_C) ? MAX_C : count_bin;
  assign inc_sum  = {1'b0, cur_bin} + (WIDTH+1)'(1);
  assign dec_diff = {1'b0, cur_bin} - (WIDTH+1)'(1);
  assign at_max   = (inc_sum > {1'b0, MAX_C});
  assign at_zero  = dec_diff[WIDTH];
  assign dir      = dir_t'(up_down);

  always_comb begin
    next_bin  = count_bin;
    tc_event  = 1'b0;
    ovf_event = 1'b0;
    unf_event = 1'b0;
    if (load) begin
      next_bin = (load_value > MAX_C) ? MAX_C : load_value;
    end else if (enable) begin
      if (dir == DIR_UP) begin
        if (at_max) begin
          next_bin  = SATURATE ? MAX_C : '0;
          tc_event  = 1'b1;
          ovf_event = 1'b1;
        end else begin
          next_bin = inc_sum[WIDTH-1:0];
        end
      end else begin
        if (at_zero) begin
          next_bin  = SATURATE ? '0 : MAX_C;
          tc_event  = 1'b1;
          unf_event = 1'b1;
        end else begin
          next_bin = dec_diff[WIDTH-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/counter_param.sv
// WIDTH-bit modulo up/down counter with load, wrap/saturate option, aligned
// Gray output, terminal-count pulse and sticky overflow/underflow flags.
module counter_param
  import counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MAX_VAL  = default_max_val(WIDTH),
  parameter bit SATURATE = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             clear_flags,
  output logic [WIDTH-1:0] count_bin,
  output logic [WIDTH-1:0] count_gray,
  output logic             terminal_count,
  output logic             overflow,
  output logic             underflow
);

  logic [WIDTH-1:0] next_bin;
  logic [WIDTH-1:0] gray_next;
  logic             tc_event;
  logic             ovf_event;
  logic             unf_event;

  logic [WIDTH-1:0] count_bin_reg;
  logic [WIDTH-1:0] count_gray_reg;
  logic             tc_reg;
  logic             ovf_reg;
  logic             unf_reg;

  counter_core #(
    .WIDTH    (WIDTH),
    .MAX_VAL  (MAX_VAL),
    .SATURATE (SATURATE)
  ) u_core (
    .count_bin  (count_bin_reg),
    .enable     (enable),
    .up_down    (up_down),
    .load       (load),
    .load_value (load_value),
    .next_bin   (next_bin),
    .tc_event   (tc_event),
    .ovf_event  (ovf_event),
    .unf_event  (unf_event)
  );

  // Gray is derived from next_bin so both outputs update on the same edge.
  assign gray_next = WIDTH'(bin2gray(GRAY_MAX_W'(next_bin)));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_bin_reg  <= '0;
      count_gray_reg <= '0;
      tc_reg         <= 1'b0;
      ovf_reg        <= 1'b0;
      unf_reg        <= 1'b0;
    end else begin
      count_bin_reg  <= next_bin;
      count_gray_reg <= gray_next;
      tc_reg         <= tc_event;
      // A fresh event outranks a clear on the same edge.
      ovf_reg        <= ovf_event | (ovf_reg & ~clear_flags);
      unf_reg        <= unf_event | (unf_reg & ~clear_flags);
    end
  end

  assign count_bin      = count_bin_reg;
  assign count_gray     = count_gray_reg;
  assign terminal_count = tc_reg;
  assign overflow       = ovf_reg;
  assign underflow      = unf_reg;

endmodule

// File: tb/tb_counter_param.sv
// Directed bench for counter_param (WIDTH=4, MAX_VAL=9): one wrapping and one
// saturating instance driven from a shared clock and reset.
module tb_counter_param;

  logic       clock = 1'b0;
  logic       reset = 1'b0;

  logic       w_enable = 1'b0, w_up_down = 1'b0, w_load = 1'b0, w_clear = 1'b0;
  logic [3:0] w_load_value = '0;
  logic [3:0] w_bin, w_gray;
  logic       w_tc, w_ovf, w_unf;

  logic       s_enable = 1'b0, s_up_down = 1'b0, s_load = 1'b0, s_clear = 1'b0;
  logic [3:0] s_load_value = '0;
  logic [3:0] s_bin, s_gray;
  logic       s_tc, s_ovf, s_unf;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  counter_param #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b0)) dut_wrap (
    .clock(clock), .reset(reset), .enable(w_enable), .up_down(w_up_down),
    .load(w_load), .load_value(w_load_value), .clear_flags(w_clear),
    .count_bin(w_bin), .count_gray(w_gray), .terminal_count(w_tc),
    .overflow(w_ovf), .underflow(w_unf)
  );

  counter_param #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b1)) dut_sat (
    .clock(clock), .reset(reset), .enable(s_enable), .up_down(s_up_down),
    .load(s_load), .load_value(s_load_value), .clear_flags(s_clear),
    .count_bin(s_bin), .count_gray(s_gray), .terminal_count(s_tc),
    .overflow(s_ovf), .underflow(s_unf)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  function automatic logic [3:0] gray_of(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check_w(input string tag, input logic [3:0] cnt, input logic tc,
                         input logic ovf, input logic unf);
    check_val({tag, ".w_bin"},  w_bin,  cnt);
    check_val({tag, ".w_gray"}, w_gray, gray_of(cnt));
    check_val({tag, ".w_tc"},   w_tc,   tc);
    check_val({tag, ".w_ovf"},  w_ovf,  ovf);
    check_val({tag, ".w_unf"},  w_unf,  unf);
  endtask

  task automatic check_s(input string tag, input logic [3:0] cnt, input logic tc,
                         input logic ovf, input logic unf);
    check_val({tag, ".s_bin"},  s_bin,  cnt);
    check_val({tag, ".s_gray"}, s_gray, gray_of(cnt));
    check_val({tag, ".s_tc"},   s_tc,   tc);
    check_val({tag, ".s_ovf"},  s_ovf,  ovf);
    check_val({tag, ".s_unf"},  s_unf,  unf);
  endtask

  // Advance one rising edge and settle past it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  logic [3:0] up_seq   [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};
  logic       up_tc    [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
  logic [3:0] down_seq [4]  = '{4'd1, 4'd0, 4'd0, 4'd0};
  logic       down_tc  [4]  = '{0, 0, 1, 1};

  initial begin
    #1;
    check_w("reset", 4'd0, 0, 0, 0);
    check_s("reset", 4'd0, 0, 0, 0);
    step();
    reset = 1'b1;

    // Up wrap: 1..9,0,1,2 with a single tc on the 9->0 edge.
    w_enable = 1'b1; w_up_down = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      check_w($sformatf("upwrap%0d", i), up_seq[i], up_tc[i], (i >= 9), 0);
    end

    // Reset mid-count at 6, between edges.
    for (int i = 0; i < 4; i++) step();
    check_w("pre_rst", 4'd6, 0, 1, 0);
    #2 reset = 1'b0;
    #1;
    check_w("mid_rst", 4'd0, 0, 0, 0);
    step();
    reset = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      check_w($sformatf("post_rst%0d", i), 4'(i), 0, 0, 0);
    end

    // Hold at 7 while toggling up_down.
    w_load = 1'b1; w_load_value = 4'd7;
    step();
    check_w("load7", 4'd7, 0, 0, 0);
    w_load = 1'b0; w_enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      w_up_down = ~w_up_down;
      step();
      check_w($sformatf("hold%0d", i), 4'd7, 0, 0, 0);
    end

    // Load priority over enable, and clamp to MAX_VAL.
    w_load = 1'b1; w_load_value = 4'd13; w_enable = 1'b1; w_up_down = 1'b1;
    step();
    check_w("load13", 4'd9, 0, 0, 0);
    w_load_value = 4'd4;
    step();
    check_w("load4", 4'd4, 0, 0, 0);
    w_load_value = 4'd9;
    step();
    check_w("load9", 4'd9, 0, 0, 0);

    // Clear on the same edge as a wrap: event wins.
    w_load = 1'b0; w_clear = 1'b1;
    step();
    check_w("clr_wrap", 4'd0, 1, 1, 0);
    w_clear = 1'b0; w_up_down = 1'b0;
    step();
    check_w("down_wrap", 4'd9, 1, 1, 1);
    step();
    check_w("down8", 4'd8, 0, 1, 1);
    w_enable = 1'b0; w_clear = 1'b1;
    step();
    check_w("clr_only", 4'd8, 0, 0, 0);
    w_clear = 1'b0;

    // Saturating instance: down from 2 holds at 0 with tc on each hold edge.
    s_load = 1'b1; s_load_value = 4'd2;
    step();
    check_s("s_load2", 4'd2, 0, 0, 0);
    s_load = 1'b0; s_enable = 1'b1; s_up_down = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check_s($sformatf("s_down%0d", i), down_seq[i], down_tc[i], 0, (i >= 2));
    end

    // Saturating up at MAX_VAL.
    s_load = 1'b1; s_load_value = 4'd9;
    step();
    check_s("s_load9", 4'd9, 0, 0, 1);
    s_load = 1'b0; s_up_down = 1'b1;
    step();
    check_s("s_sat_up", 4'd9, 1, 1, 1);
    s_enable = 1'b0;
    step();
    check_s("s_idle", 4'd9, 0, 1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/counter_param.md
Name: counter_param

Overview:
Parametrised successor to the team's fixed 4-bit counter. It is a WIDTH-bit modulo counter with up/down direction, synchronous load, count enable, and a choice of wrap or saturate at the limits. It drives binary and Gray-coded outputs plus terminal-count and sticky-event flags. It is used as the generic counter and timebase building block in lab designs.

Parameters:
WIDTH, 4, counter width in bits (>=2)
MAX_VAL, 2**WIDTH-1, highest count value; the count range is 0..MAX_VAL (1 <= MAX_VAL <= 2**WIDTH-1)
SATURATE, 0, 0 = wrap at the limits, 1 = hold at the limits

Ports:
clock  input  1  system clock; all state changes on its rising edge
reset  input  1  asynchronous, active-low reset
enable  input  1  count enable
up_down  input  1  1 = count up, 0 = count down
load  input  1  synchronous load strobe
load_value  input  WIDTH  value to load
clear_flags  input  1  synchronous clear of the sticky flags
count_bin  output  WIDTH  registered binary count
count_gray  output  WIDTH  registered Gray code of count_bin
terminal_count  output  1  registered one-cycle pulse on a wrap or saturation event
overflow  output  1  sticky flag: an up-count at MAX_VAL has occurred
underflow  output  1  sticky flag: a down-count at 0 has occurred

Behaviour:
- Clock and reset:
  - One clock; reset is asynchronous and active-low.
  - reset=0 forces every output to 0 immediately, independent of clock.
  - Release is synchronous: the first active edge after reset=1 behaves normally.
  - Reset asserted mid-count aborts the count; no flag or pulse is generated.
- Priority per rising edge: load > enable > hold.
- Load:
  - load=1 sets count_bin = min(load_value, MAX_VAL); enable and up_down are ignored.
  - Load never sets terminal_count, overflow or underflow.
- Enable with up_down=1:
  - count < MAX_VAL: count+1.
  - count = MAX_VAL: next count is 0 (SATURATE=0) or MAX_VAL (SATURATE=1). terminal_count=1 for that one cycle; overflow sets.
- Enable with up_down=0:
  - count > 0: count-1.
  - count = 0: next count is MAX_VAL (SATURATE=0) or 0 (SATURATE=1). terminal_count=1 for one cycle; underflow sets.
- Saturated hold: while saturated and still enabled toward the limit, terminal_count pulses on every such edge and the flag stays set.
- enable=0 and load=0: count holds; terminal_count=0.
- Latency: one cycle from input sampling to count_bin change.
- Gray output:
  - count_gray = next_bin ^ (next_bin >> 1), registered on the same edge as count_bin. The two outputs are always aligned, with zero relative latency.
  - Gray is single-bit-change only when MAX_VAL = 2**WIDTH-1; otherwise the wrap edge may change several bits. This is accepted, not an error.
- Sticky flags:
  - clear_flags=1 clears overflow and underflow at the edge.
  - If clear_flags and a new event occur on the same edge, the new event wins (flag = 1).
- Arithmetic: modulo detection compares against MAX_VAL as a WIDTH-bit constant. Intermediate sums use WIDTH+1 bits, so no silent truncation occurs.
- No illegal states: any register value above MAX_VAL (reachable only by X/fault) is treated as MAX_VAL on the next enable.

Decomposition:
- Package counter_pkg holds:
  - typedef enum logic {DIR_DOWN=0, DIR_UP=1} dir_t
  - function bin2gray(input [WIDTH-1:0])
  - localparam helpers for the default MAX_VAL
- Sub-module counter_core is a natural split: it holds the next-state and limit logic and returns next_bin plus event bits. The top level registers count_bin, count_gray and the flags.

Test Plan:
(All scenarios use WIDTH=4, MAX_VAL=9.)
- Reset mid-count: count reaches 6, then reset=0 between clock edges -> all outputs 0 immediately. After release with enable=1 and up_down=1, the sequence is 1,2,3.
- Up wrap (SATURATE=0): enable=1, up_down=1 from 0 for 12 edges -> 1..9,0,1,2. terminal_count is high exactly on the 9->0 edge and overflow=1 afterwards. count_gray tracks bin2gray(count_bin) every cycle.
- Down saturate (SATURATE=1): load_value=2, then enable=1, up_down=0 for 4 edges -> 2,1,0,0,0. terminal_count pulses on both hold edges at 0; underflow=1.
- Load priority and clamp: load=1 with load_value=13 and enable=1 on the same edge -> count=9 and terminal_count=0. With load=1, load_value=4 -> count=4.
- Flags: clear_flags=1 on the same edge as a 9->0 wrap -> overflow stays 1. clear_flags=1 alone on a later edge -> overflow=0 and underflow=0.
- Hold: enable=0 for 5 edges at count=7 -> count stays 7 and terminal_count stays 0. Toggling up_down while disabled has no effect.
